// File: rtl/modexp_controller.sv
// Montgomery modular exponentiation sequencer: drives one R^2 precompute
// unit and one shared Montgomery multiplier through a left-to-right ladder.
module modexp_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int EXP_WIDTH  = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] modulant,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [EXP_WIDTH-1:0]  exponent,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] n_out,
  output logic                  rc_start,
  input  logic                  rc_done,
  input  logic [DATA_WIDTH-1:0] rc_r_square,
  output logic                  mm_start,
  output logic [DATA_WIDTH-1:0] mm_a,
  output logic [DATA_WIDTH-1:0] mm_b,
  input  logic [DATA_WIDTH-1:0] mm_result,
  input  logic                  mm_done
);

  localparam int CW = $clog2(EXP_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(EXP_WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TO_MONT_BASE,
    TO_MONT_ONE,
    SQUARE,
    MULTIPLY,
    FROM_MONT,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   n_q, n_d;
  logic [EXP_WIDTH-1:0]    e_q, e_d;
  logic [DATA_WIDTH-1:0]   r2_q, r2_d;
  logic [DATA_WIDTH-1:0]   basem_q, basem_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    issue_q, issue_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    rc_start_q, rc_start_d;
  logic                    mm_start_q, mm_start_d;
  logic [DATA_WIDTH-1:0]   mm_a_q, mm_a_d;
  logic [DATA_WIDTH-1:0]   mm_b_q, mm_b_d;
  logic                    mm_ok;
  logic                    last_bit;

  // Done levels are stale during the issue cycle, so only trust them after.
  assign mm_ok    = !issue_q && mm_done;
  assign last_bit = (cnt_q == CNT_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      e_q        <= '0;
      r2_q       <= '0;
      basem_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      issue_q    <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      rc_start_q <= 1'b0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      e_q        <= e_d;
      r2_q       <= r2_d;
      basem_q    <= basem_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      issue_q    <= issue_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      rc_start_q <= rc_start_d;
      mm_start_q <= mm_start_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    e_d        = e_q;
    r2_d       = r2_q;
    basem_d    = basem_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    issue_d    = 1'b0;
    result_d   = result_q;
    done_d     = done_q;
    rc_start_d = 1'b0;
    mm_start_d = 1'b0;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d        = modulant;
          e_d        = exponent;
          basem_d    = base;
          cnt_d      = CNT_LOAD;
          done_d     = 1'b0;
          rc_start_d = 1'b1;
          issue_d    = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (!issue_q && rc_done) begin
          r2_d       = rc_r_square;
          mm_start_d = 1'b1;
          issue_d    = 1'b1;
          mm_a_d     = basem_q;
          mm_b_d     = rc_r_square;
          state_d    = TO_MONT_BASE;
        end
      end
      TO_MONT_BASE: begin
        if (mm_ok) begin
          basem_d    = mm_result;
          mm_start_d = 1'b1;
          issue_d    = 1'b1;
          mm_a_d     = ONE;
          mm_b_d     = r2_q;
          state_d    = TO_MONT_ONE;
        end
      end
      TO_MONT_ONE: begin
        if (mm_ok) begin
          acc_d      = mm_result;
          mm_start_d = 1'b1;
          issue_d    = 1'b1;
          mm_a_d     = mm_result;
          mm_b_d     = mm_result;
          state_d    = SQUARE;
        end
      end
      SQUARE, MULTIPLY: begin
        if (mm_ok) begin
          acc_d      = mm_result;
          mm_start_d = 1'b1;
          issue_d    = 1'b1;
          mm_a_d     = mm_result;
          if (state_q == SQUARE && e_q[EXP_WIDTH-1]) begin
            mm_b_d  = basem_q;
            state_d = MULTIPLY;
          end else begin
            e_d   = e_q << 1;
            cnt_d = cnt_q - CNT_ONE;
            if (last_bit) begin
              mm_b_d  = ONE;
              state_d = FROM_MONT;
            end else begin
              mm_b_d  = mm_result;
              state_d = SQUARE;
            end
          end
        end
      end
      FROM_MONT: begin
        if (mm_ok) begin
          result_d = mm_result;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = !(state_d == IDLE || state_d == DONE);
  end

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign n_out    = n_q;
  assign rc_start = rc_start_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;

endmodule

// File: tb/tb_modexp_controller.sv
// Directed bench for modexp_controller with behavioural R^2 and
// Montgomery multiplier units (fixed or random latency).
module tb_modexp_controller;

  localparam int DW = 8;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] modulant;
  logic [DW-1:0] base;
  logic [EW-1:0] exponent;
  logic [DW-1:0] result;
  logic          done;
  logic          busy;
  logic [DW-1:0] n_out;
  logic          rc_start;
  logic          rc_done;
  logic [DW-1:0] rc_r_square;
  logic          mm_start;
  logic [DW-1:0] mm_a;
  logic [DW-1:0] mm_b;
  logic [DW-1:0] mm_result;
  logic          mm_done;

  int checks = 0;
  int errors = 0;

  bit rand_lat = 1'b0;
  int mm_starts = 0;
  int rc_starts = 0;
  int op_viol = 0;
  int mm_left = 0;
  int rc_left = 0;
  bit track = 1'b0;
  logic [DW-1:0] la, lb, ln, rn;

  always #5 clk = ~clk;

  modexp_controller #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .modulant(modulant),
    .base(base),
    .exponent(exponent),
    .result(result),
    .done(done),
    .busy(busy),
    .n_out(n_out),
    .rc_start(rc_start),
    .rc_done(rc_done),
    .rc_r_square(rc_r_square),
    .mm_start(mm_start),
    .mm_a(mm_a),
    .mm_b(mm_b),
    .mm_result(mm_result),
    .mm_done(mm_done)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mont(input int a, input int b, input int n);
    int rinv;
    rinv = 0;
    if (n < 2) return 0;
    for (int x = 1; x < n; x++)
      if ((x * 256) % n == 1) rinv = x;
    return (((a * b) % n) * rinv) % n;
  endfunction

  // Units clear done one cycle after start, leaving it stale in the issue cycle.
  always @(posedge clk) begin
    if (mm_start) begin
      mm_starts++;
      la <= mm_a;
      lb <= mm_b;
      ln <= n_out;
      mm_done <= 1'b0;
      mm_left <= rand_lat ? int'($urandom_range(1, 10)) : 1;
      track <= 1'b1;
    end else if (mm_left > 0) begin
      if (track && !reset && (mm_a !== la || mm_b !== lb))
        op_viol++;
      if (mm_left == 1) begin
        mm_done <= 1'b1;
        mm_result <= DW'(mont(int'(la), int'(lb), int'(ln)));
      end
      mm_left <= mm_left - 1;
    end
    if (reset) track <= 1'b0;
  end

  always @(posedge clk) begin
    if (rc_start) begin
      rc_starts++;
      rn <= n_out;
      rc_done <= 1'b0;
      rc_left <= rand_lat ? int'($urandom_range(1, 10)) : 1;
    end else if (rc_left > 0) begin
      if (rc_left == 1) begin
        rc_done <= 1'b1;
        rc_r_square <= (rn == 0) ? '0 : DW'(65536 % int'(rn));
      end
      rc_left <= rc_left - 1;
    end
  end

  task automatic run(input string tag, input logic [DW-1:0] n,
                     input logic [DW-1:0] b, input logic [EW-1:0] e,
                     input logic [DW-1:0] exp_res, input int exp_mm,
                     input bit glitch);
    int cyc;
    mm_starts = 0;
    rc_starts = 0;
    op_viol = 0;
    @(negedge clk);
    modulant = n;
    base = b;
    exponent = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done_lo"}, 32'(done), 32'd0);
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (glitch && cyc == 5) begin
        modulant = 8'd251;
        base = 8'd7;
        exponent = 8'd255;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_res"}, 32'(result), 32'(exp_res));
    check({tag, "_mm"}, 32'(mm_starts), 32'(exp_mm));
    check({tag, "_rc"}, 32'(rc_starts), 32'd1);
    check({tag, "_opstab"}, 32'(op_viol), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int g;
    reset = 1'b1;
    start = 1'b0;
    modulant = '0;
    base = '0;
    exponent = '0;
    mm_done = 1'b0;
    rc_done = 1'b0;
    mm_result = '0;
    rc_r_square = '0;
    la = '0;
    lb = '0;
    ln = '0;
    rn = '0;
    repeat (2) @(negedge clk);
    check("rst_ctl", 32'({done, busy, rc_start, mm_start}), 32'd0);
    check("rst_data", 32'({result, mm_a, mm_b, n_out}), 32'd0);
    reset = 1'b0;

    run("p2e5", 8'd13, 8'd2, 8'd5, 8'd6, 13, 1'b0);
    run("p9e0", 8'd13, 8'd9, 8'd0, 8'd1, 11, 1'b0);
    run("p7e255", 8'd251, 8'd7, 8'd255, 8'd241, 19, 1'b0);
    run("p0e3", 8'd13, 8'd0, 8'd3, 8'd0, 13, 1'b0);

    rand_lat = 1'b1;
    run("rnd_p2e5", 8'd13, 8'd2, 8'd5, 8'd6, 13, 1'b0);
    run("rnd_p7e255", 8'd251, 8'd7, 8'd255, 8'd241, 19, 1'b0);

    mm_starts = 0;
    @(negedge clk);
    modulant = 8'd13;
    base = 8'd2;
    exponent = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (mm_starts < 4 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("sq_reached", 32'(mm_starts), 32'd4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ctl", 32'({done, busy, rc_start, mm_start}), 32'd0);
    check("midrst_data", 32'({result, mm_a, mm_b, n_out}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_idle", 32'(busy), 32'd0);

    run("ign_start", 8'd13, 8'd2, 8'd5, 8'd6, 13, 1'b1);
    run("b2b_a", 8'd251, 8'd7, 8'd255, 8'd241, 19, 1'b0);
    run("b2b_b", 8'd13, 8'd9, 8'd0, 8'd1, 11, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modexp_controller.md
# modexp_controller

Sequencer for Montgomery modular exponentiation, result = base^exponent mod modulant. It first launches the R-precompute unit to obtain R² mod N. It then drives a single shared Montgomery multiplier through the conversion, square-and-multiply and reconversion steps. It sits between the top-level crypto control and the R-precompute / Montgomery-multiplier datapath.

## Interface
- DATA_WIDTH, 8: width of modulant, base, operands and result
- EXP_WIDTH, DATA_WIDTH: exponent width; every bit is processed, MSB first
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- start  in  1  launch request; sampled only in IDLE or DONE
- modulant  in  DATA_WIDTH  N; odd, ≥3; latched on accepted start
- base  in  DATA_WIDTH  must be < N; latched on accepted start
- exponent  in  EXP_WIDTH  latched on accepted start
- result  out  DATA_WIDTH  final value; held until next accepted start
- done  out  1  level, high from completion until next accepted start
- busy  out  1  high in every state except IDLE and DONE
- n_out  out  DATA_WIDTH  latched N, drives rc/mm modulant inputs
- rc_start  out  1  one-cycle pulse to R-precompute unit
- rc_done  in  1  level done from R-precompute unit
- rc_r_square  in  DATA_WIDTH  R² mod N, valid while rc_done high
- mm_start  out  1  one-cycle pulse to Montgomery multiplier
- mm_a, mm_b  out  DATA_WIDTH  operands, stable from mm_start until mm_done sampled
- mm_result  in  DATA_WIDTH  a·b·R⁻¹ mod N, valid while mm_done high
- mm_done  in  1  level done from multiplier

## Operation
- States: IDLE, SETUP, TO_MONT_BASE, TO_MONT_ONE, SQUARE, MULTIPLY, FROM_MONT, DONE.
- Registers: n, e (EXP_WIDTH shift register), r2, base_m, acc, bit counter (width clog2(EXP_WIDTH+1)), issue flag.
- IDLE/DONE + start: latch operands, clear done, load bit counter with EXP_WIDTH, go to SETUP. In other states, start is ignored.
- SETUP: pulse rc_start on entry. When rc_done is sampled high, capture r2 = rc_r_square.
- TO_MONT_BASE: multiply mm_a = base, mm_b = r2, giving base_m.
- TO_MONT_ONE: multiply mm_a = 1, mm_b = r2, giving acc (R mod N).
- SQUARE: multiply acc·acc into acc. Then, if e[MSB] = 1, go to MULTIPLY; otherwise shift e left, decrement the counter, and loop back or exit.
- MULTIPLY: multiply acc·base_m into acc, then shift e, decrement the counter, and loop back or exit.
- Exit (counter reaches 0): go to FROM_MONT.
- FROM_MONT: multiply acc·1. Capture result = mm_result, set done, go to DONE.
- Every multiply state:
  - issue cycle: mm_start = 1, operands driven;
  - wait cycles: mm_start = 0, operands held;
  - capture occurs in the first cycle mm_done is sampled high after the issue cycle.
- mm_done and rc_done are ignored in the issue cycle itself, because the units clear done on start one cycle late.
- Operation counts: multiplier starts = 3 + EXP_WIDTH + popcount(exponent); rc_start pulses = 1.
- exponent = 0: result = 1 mod N = 1.
- base = 0: result = 0 unless exponent = 0.
- N even, N < 3, or base ≥ N: result unspecified, but the sequence still terminates.

## Timing
- Reset values: state IDLE, done = 0, busy = 0, result = 0, rc_start = 0, mm_start = 0, mm_a = 0, mm_b = 0, n_out = 0.
- Reset asserted mid-operation: immediate return to IDLE. The shared units are not aborted, and their pending done is ignored.
- All outputs are registered.
- Accepted start at edge t: SETUP entered at t+1, rc_start high during cycle t+1.
- If rc_done is first seen k ≥ 1 cycles after the issue cycle, the next state's issue cycle follows 1 cycle later. The same rule applies to each multiply.
- Total latency = 1 + Σ(1 + k_i + 1) over all unit operations.
- done rises on the edge after the FROM_MONT capture, together with result.
- A start in the cycle done is high is accepted; done drops the next cycle.

## Test plan
- N=13, base=2, exponent=5, EXP_WIDTH=8 (ideal multiplier model) → result=6, done high; exactly 13 mm_start pulses and 1 rc_start.
- N=13, base=9, exponent=0 → result=1; exactly 11 mm_start pulses.
- N=251, base=7, exponent=255 → result=241; 19 mm_start pulses.
- N=13, base=0, exponent=3 → result=0.
- Multiplier model with random 1–10 cycle latency, done left high from the previous operation → result unchanged (6 for the first case); operands stable throughout each wait.
- Assert reset during SQUARE → all outputs 0 next cycle. start then asserted while busy is ignored. Back-to-back starts from DONE each produce the correct result.
